// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_queue_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } FetchInfo;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            error;
  } FetchEntry;

endpackage

// File: rtl/fetch_ring.sv
// In-order fetch buffer: allocate at tail, fill at fill pointer, pop at head.
module fetch_ring
  import fetch_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_alloc,
  input  logic [XLEN-1:0]  i_alloc_pc,
  input  logic             i_fill,
  input  logic [XLEN-1:0]  i_fill_inst,
  input  logic             i_fill_error,
  input  logic             i_pop,
  output FetchEntry        o_head,
  output logic [PTR_W:0]   o_head_ptr,
  output logic [PTR_W:0]   o_fill_ptr,
  output logic [PTR_W:0]   o_tail_ptr
);

  localparam int unsigned CNT_W = PTR_W + 1;

  FetchEntry      r_mem [DEPTH];
  logic [PTR_W:0] r_head;
  logic [PTR_W:0] r_fill;
  logic [PTR_W:0] r_tail;

  // Pointers carry an extra MSB so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_head <= '0;
      r_fill <= '0;
      r_tail <= '0;
    end else begin
      if (i_alloc) r_tail <= r_tail + CNT_W'(1);
      if (i_fill)  r_fill <= r_fill + CNT_W'(1);
      if (i_pop)   r_head <= r_head + CNT_W'(1);
    end
  end

  // Alloc and fill never target the same slot: a full ring blocks alloc.
  always_ff @(posedge clk) begin
    if (!rst && !i_clear) begin
      if (i_alloc) r_mem[r_tail[PTR_W-1:0]].pc <= i_alloc_pc;
      if (i_fill) begin
        r_mem[r_fill[PTR_W-1:0]].inst  <= i_fill_inst;
        r_mem[r_fill[PTR_W-1:0]].error <= i_fill_error;
      end
    end
  end

  assign o_head     = r_mem[r_head[PTR_W-1:0]];
  assign o_head_ptr = r_head;
  assign o_fill_ptr = r_fill;
  assign o_tail_ptr = r_tail;

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: owns the fetch PC, issues icache requests and
// buffers responses in order for IF/ID; redirects discard stale fetches.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ic_req_valid,
  input  logic            ic_req_ready,
  output logic [XLEN-1:0] ic_req_addr,
  input  logic            ic_resp_valid,
  input  logic [XLEN-1:0] ic_resp_inst,
  input  logic            ic_resp_error,
  output logic            out_valid,
  input  logic            out_ready,
  output FetchInfo        out_info,
  output logic            out_error
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned DROP_W = PTR_W + 1;
  localparam int unsigned CNT_W  = PTR_W + 2;

  logic [XLEN-1:0]  r_fetch_pc;
  logic [DROP_W-1:0] r_drop_cnt;
  logic             r_halted;

  FetchEntry        w_head_entry;
  logic [PTR_W:0]   w_head;
  logic [PTR_W:0]   w_fill;
  logic [PTR_W:0]   w_tail;
  logic [PTR_W:0]   w_alloc_cnt;
  logic [PTR_W:0]   w_outstanding;
  logic             w_req_fire;
  logic             w_resp_drop;
  logic             w_resp_live;
  logic             w_pop;
  logic [CNT_W-1:0] w_drop_sum;
  logic [CNT_W-1:0] w_drop_redirect;

  assign w_alloc_cnt   = w_tail - w_head;
  assign w_outstanding = w_tail - w_fill;

  // Dropped responses still occupy icache slots, so they count against capacity.
  assign ic_req_valid = !r_halted && !redirect_valid &&
                        ((CNT_W'(w_alloc_cnt) + CNT_W'(r_drop_cnt)) < CNT_W'(DEPTH));
  assign ic_req_addr  = r_fetch_pc;
  assign w_req_fire   = ic_req_valid && ic_req_ready;

  assign w_resp_drop  = ic_resp_valid && (r_drop_cnt != '0);
  assign w_resp_live  = ic_resp_valid && (r_drop_cnt == '0) && (w_outstanding != '0);

  assign out_valid    = (w_fill != w_head);
  assign w_pop        = out_valid && out_ready && !redirect_valid;

  // Stale in-flight count after a redirect, minus any response landing this cycle.
  assign w_drop_sum = CNT_W'(r_drop_cnt) + CNT_W'(w_outstanding);
  always_comb begin
    w_drop_redirect = w_drop_sum;
    if (ic_resp_valid && (w_drop_sum != '0)) w_drop_redirect = w_drop_sum - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_drop_cnt <= '0;
      r_halted   <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc & ~32'h0000_0003;
      r_drop_cnt <= DROP_W'(w_drop_redirect);
      r_halted   <= 1'b0;
    end else begin
      if (w_req_fire)                  r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_resp_drop)                 r_drop_cnt <= r_drop_cnt - DROP_W'(1);
      if (w_resp_live && ic_resp_error) r_halted  <= 1'b1;
    end
  end

  fetch_ring #(.DEPTH(DEPTH)) u_ring (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (redirect_valid),
    .i_alloc      (w_req_fire),
    .i_alloc_pc   (r_fetch_pc),
    .i_fill       (w_resp_live),
    .i_fill_inst  (ic_resp_inst),
    .i_fill_error (ic_resp_error),
    .i_pop        (w_pop),
    .o_head       (w_head_entry),
    .o_head_ptr   (w_head),
    .o_fill_ptr   (w_fill),
    .o_tail_ptr   (w_tail)
  );

  // Head entry is presented as zeros while the buffer holds nothing ready.
  always_comb begin
    out_info  = '0;
    out_error = 1'b0;
    if (out_valid) begin
      out_info.pc   = w_head_entry.pc;
      out_info.inst = w_head_entry.inst;
      out_error     = w_head_entry.error;
    end
  end

endmodule
